// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator over a raster-order 8-bit image.
// Two line buffers plus a 3x3 shift window; one window per accepted pixel once x>=2, y>=2.
module window_gen_3x3 #(
    parameter int unsigned IMG_W = 256,
    parameter int unsigned IMG_H = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_pixel,
    input  logic        in_sof,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [71:0] pixel_batch,
    output logic        out_last
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    typedef enum logic {FILL, RUN} state_t;

    state_t         state;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;

    logic [7:0]     lb0 [IMG_W];
    logic [7:0]     lb1 [IMG_W];
    logic [2:0][2:0][7:0] win;
    logic [2:0][2:0][7:0] win_next;

    logic           accept;
    logic           produce;
    logic [XW-1:0]  ex;
    logic [YW-1:0]  ey;
    logic           x_end;
    logic           y_end;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Effective position of this pixel: a start-of-frame forces (0,0).
    always_comb begin
        ex       = in_sof ? '0 : x;
        ey       = in_sof ? '0 : y;
        x_end    = (ex == XW'(IMG_W - 1));
        y_end    = (ey == YW'(IMG_H - 1));
        produce  = accept && (state == RUN) && !in_sof && (ex >= XW'(2));
        win_next = win;
        for (int r = 0; r < 3; r++) begin
            win_next[r][0] = win[r][1];
            win_next[r][1] = win[r][2];
        end
        win_next[0][2] = lb1[ex];
        win_next[1][2] = lb0[ex];
        win_next[2][2] = in_pixel;
    end

    // Position counters, fill/run state and the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FILL;
            x           <= '0;
            y           <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            pixel_batch <= '0;
        end else begin
            if (accept) begin
                if (x_end) begin
                    x <= '0;
                    y <= y_end ? '0 : ey + YW'(1);
                end else begin
                    x <= ex + XW'(1);
                    y <= ey;
                end
                if (in_sof || (x_end && y_end)) begin
                    state <= FILL;
                end else if (x_end && (ey == YW'(1))) begin
                    state <= RUN;
                end
            end
            if (produce) begin
                out_valid   <= 1'b1;
                out_last    <= x_end && y_end;
                pixel_batch <= win_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Line buffers and window carry only data, so they are left out of reset.
    always_ff @(posedge clk) begin
        if (accept && rst_n) begin
            lb1[ex] <= lb0[ex];
            lb0[ex] <= in_pixel;
            win     <= win_next;
        end
    end

endmodule
